frame_ones_counter: RTL and testbench



---
 rtl/frame_ones_counter.sv | 166 ++++++++++++++++
 tb/tb_frame_ones_counter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_ones_counter.sv
// ---------------------------------------------------------------------------
// frame_ones_counter
//
// Streaming stage that accepts a framed byte stream and reports, for each
// frame, the total number of set bits and the number of beats it carried.
// Both totals are CNT_W wide and saturate at all-ones. A sticky flag reports
// whether either total saturated during the frame.
//
// Ports
//   clk        : single clock, rising edge
//   rst        : asynchronous, active-high reset
//   in_valid   : input beat valid
//   in_ready   : block can accept a beat (low while in reset and in HOLD)
//   in_data    : beat payload, DATA_W bits
//   in_last    : final beat of the frame, sampled only on an accepted beat
//   out_valid  : frame result valid
//   out_ready  : consumer accepts the result
//   out_ones   : total set bits in the frame (saturating)
//   out_bytes  : number of beats in the frame (saturating)
//   out_sat    : a counter saturated during this frame
// ---------------------------------------------------------------------------
module frame_ones_counter #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_ones,
  output logic [CNT_W-1:0]  out_bytes,
  output logic              out_sat
);

  // Wide enough to hold DATA_W itself, so an all-ones beat is never truncated.
  localparam int POP_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] ones_acc_q, ones_acc_d;
  logic [CNT_W-1:0] bytes_acc_q, bytes_acc_d;
  logic             sat_q, sat_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] out_ones_q, out_ones_d;
  logic [CNT_W-1:0] out_bytes_q, out_bytes_d;
  logic             out_sat_q, out_sat_d;

  logic [POP_W-1:0] beat_pop;
  logic [CNT_W:0]   ones_sum;
  logic [CNT_W:0]   bytes_sum;
  logic [CNT_W-1:0] ones_next;
  logic [CNT_W-1:0] bytes_next;
  logic             sat_next;
  logic             accept;

  // Per-beat population count.
  always_comb begin
    beat_pop = '0;
    for (int i = 0; i < DATA_W; i++) begin
      beat_pop = beat_pop + POP_W'(in_data[i]);
    end
  end

  // Sums carry one extra bit; that bit is the "requested sum > max" signal.
  assign ones_sum   = {1'b0, ones_acc_q} + (CNT_W + 1)'(beat_pop);
  assign bytes_sum  = {1'b0, bytes_acc_q} + (CNT_W + 1)'(1);
  assign ones_next  = ones_sum[CNT_W]  ? CNT_MAX : ones_sum[CNT_W-1:0];
  assign bytes_next = bytes_sum[CNT_W] ? CNT_MAX : bytes_sum[CNT_W-1:0];
  assign sat_next   = sat_q | ones_sum[CNT_W] | bytes_sum[CNT_W];

  // Ready is a decode of registered state only; out_ready never reaches it.
  // Gating with rst keeps it low for the whole reset pulse.
  assign in_ready = !rst && (state_q != HOLD);
  assign accept   = in_valid && in_ready;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d     = state_q;
    ones_acc_d  = ones_acc_q;
    bytes_acc_d = bytes_acc_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q;
    out_ones_d  = out_ones_q;
    out_bytes_d = out_bytes_q;
    out_sat_d   = out_sat_q;

    case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          ones_acc_d  = ones_next;
          bytes_acc_d = bytes_next;
          sat_d       = sat_next;
          if (in_last) begin
            // Result registers capture totals that already include this beat.
            state_d     = HOLD;
            out_valid_d = 1'b1;
            out_ones_d  = ones_next;
            out_bytes_d = bytes_next;
            out_sat_d   = sat_next;
          end else begin
            state_d = ACCUM;
          end
        end
      end

      HOLD: begin
        if (out_ready) begin
          // out_ones/out_bytes keep their last value; only the flag clears.
          state_d     = IDLE;
          out_valid_d = 1'b0;
          out_sat_d   = 1'b0;
          ones_acc_d  = '0;
          bytes_acc_d = '0;
          sat_d       = 1'b0;
        end
      end

      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        ones_acc_d  = '0;
        bytes_acc_d = '0;
        sat_d       = 1'b0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ones_acc_q  <= '0;
      bytes_acc_q <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_ones_q  <= '0;
      out_bytes_q <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ones_acc_q  <= ones_acc_d;
      bytes_acc_q <= bytes_acc_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
      out_ones_q  <= out_ones_d;
      out_bytes_q <= out_bytes_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_ones  = out_ones_q;
  assign out_bytes = out_bytes_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_frame_ones_counter.sv
// ---------------------------------------------------------------------------
// tb_frame_ones_counter
//
// Two instances share one input stream and one out_ready: the default
// CNT_W=16 build and a CNT_W=4 build that saturates quickly. A frame-level
// model (running sums of $countones per accepted beat, clamped at the
// counter maximum) predicts each result; a negedge process compares both
// instances against it every cycle. Directed frames with hand-computed
// literal results come first, then a randomized stream with random gaps,
// frame lengths, backpressure and occasional resets.
// ---------------------------------------------------------------------------
module tb_frame_ones_counter;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_ready;

  logic        in_ready,   out_valid,   out_sat;
  logic [15:0] out_ones,   out_bytes;
  logic        in_ready_s, out_valid_s, out_sat_s;
  logic [3:0]  out_ones_s, out_bytes_s;

  int n_total;
  int n_pass;

  frame_ones_counter #(.DATA_W(8), .CNT_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ones (out_ones),
    .out_bytes(out_bytes),
    .out_sat  (out_sat)
  );

  frame_ones_counter #(.DATA_W(8), .CNT_W(4)) dut_s (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready_s),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid_s),
    .out_ready(out_ready),
    .out_ones (out_ones_s),
    .out_bytes(out_bytes_s),
    .out_sat  (out_sat_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // ---------------- frame-level reference model ----------------
  bit holding;
  int frame_ones;
  int frame_bytes;
  int exp_ones16, exp_bytes16, exp_ones4, exp_bytes4;
  bit exp_sat16, exp_sat4;

  always @(posedge clk or posedge rst) begin : model
    int n_ones;
    int n_bytes;
    if (rst) begin
      holding     <= 1'b0;
      frame_ones  <= 0;
      frame_bytes <= 0;
    end else if (holding) begin
      if (out_ready) holding <= 1'b0;
    end else if (in_valid) begin
      n_ones  = frame_ones + $countones(in_data);
      n_bytes = frame_bytes + 1;
      if (in_last) begin
        holding     <= 1'b1;
        exp_ones16  <= (n_ones  > 65535) ? 65535 : n_ones;
        exp_bytes16 <= (n_bytes > 65535) ? 65535 : n_bytes;
        exp_sat16   <= (n_ones > 65535) || (n_bytes > 65535);
        exp_ones4   <= (n_ones  > 15) ? 15 : n_ones;
        exp_bytes4  <= (n_bytes > 15) ? 15 : n_bytes;
        exp_sat4    <= (n_ones > 15) || (n_bytes > 15);
        frame_ones  <= 0;
        frame_bytes <= 0;
      end else begin
        frame_ones  <= n_ones;
        frame_bytes <= n_bytes;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    check("in_ready",    in_ready,    !rst && !holding);
    check("in_ready_s",  in_ready_s,  !rst && !holding);
    check("out_valid",   out_valid,   holding);
    check("out_valid_s", out_valid_s, holding);
    if (holding) begin
      check("out_ones",    out_ones,    exp_ones16);
      check("out_bytes",   out_bytes,   exp_bytes16);
      check("out_sat",     out_sat,     exp_sat16);
      check("out_ones_s",  out_ones_s,  exp_ones4);
      check("out_bytes_s", out_bytes_s, exp_bytes4);
      check("out_sat_s",   out_sat_s,   exp_sat4);
    end
  end

  // ---------------- stimulus helpers ----------------
  // Starts and ends just after a rising edge; returns after the accepting edge.
  task automatic send_beat(input logic [7:0] d, input logic l, input int gap);
    bit done;
    int n;
    in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    done = 1'b0;
    n = 0;
    while (!done && n < 50) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!done) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_total   = 0;
    n_pass    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    out_ready = 1'b1;

    // Reset state.
    #1;
    check("rst_in_ready",  in_ready,  0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_ones",  out_ones,  0);
    check("rst_out_bytes", out_bytes, 0);
    check("rst_out_sat",   out_sat,   0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    step();

    // Back-to-back three-beat frame.
    send_beat(8'hFF, 1'b0, 0);
    send_beat(8'h0F, 1'b0, 0);
    send_beat(8'h01, 1'b1, 0);
    @(negedge clk);
    check("t1_valid",   out_valid,   1);
    check("t1_ones",    out_ones,    13);
    check("t1_bytes",   out_bytes,   3);
    check("t1_sat",     out_sat,     0);
    check("t1_ones_s",  out_ones_s,  13);
    check("t1_bytes_s", out_bytes_s, 3);
    check("t1_ready",   in_ready,    0);
    step();
    @(negedge clk);
    check("t1_valid_drop", out_valid, 0);
    check("t1_ready_back", in_ready,  1);
    step();

    // Single-beat frames.
    send_beat(8'h00, 1'b1, 0);
    @(negedge clk);
    check("t2_valid", out_valid, 1);
    check("t2_ones",  out_ones,  0);
    check("t2_bytes", out_bytes, 1);
    step();
    send_beat(8'hFF, 1'b1, 0);
    @(negedge clk);
    check("t2b_ones",   out_ones,   8);
    check("t2b_ones_s", out_ones_s, 8);
    check("t2b_bytes",  out_bytes,  1);
    step();

    // Backpressure; a beat offered during HOLD must not be taken.
    out_ready = 1'b0;
    send_beat(8'hAA, 1'b0, 0);
    send_beat(8'h55, 1'b1, 0);
    in_valid = 1'b1;
    in_data  = 8'hFF;
    in_last  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) out_ready = 1'b1;
      @(negedge clk);
      check("t3_valid", out_valid, 1);
      check("t3_ones",  out_ones,  8);
      check("t3_bytes", out_bytes, 2);
      check("t3_ready", in_ready,  0);
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    step();

    // Input gaps.
    send_beat(8'h03, 1'b0, 0);
    send_beat(8'h07, 1'b0, 3);
    send_beat(8'h80, 1'b1, 1);
    @(negedge clk);
    check("t4_ones",  out_ones,  6);
    check("t4_bytes", out_bytes, 3);
    step();

    // Saturation on the narrow instance, then a clean frame.
    send_beat(8'hFF, 1'b0, 0);
    send_beat(8'hFF, 1'b1, 0);
    @(negedge clk);
    check("t5_ones_s",  out_ones_s,  15);
    check("t5_bytes_s", out_bytes_s, 2);
    check("t5_sat_s",   out_sat_s,   1);
    check("t5_ones",    out_ones,    16);
    check("t5_sat",     out_sat,     0);
    step();
    send_beat(8'h01, 1'b1, 0);
    @(negedge clk);
    check("t5b_ones_s", out_ones_s, 1);
    check("t5b_sat_s",  out_sat_s,  0);
    step();

    // Reset mid-frame discards the partial frame.
    send_beat(8'hFF, 1'b0, 0);
    send_beat(8'h0F, 1'b0, 0);
    rst = 1'b1;
    #1;
    check("t6_rst_ready", in_ready, 0);
    step();
    rst = 1'b0;
    send_beat(8'h0F, 1'b1, 0);
    @(negedge clk);
    check("t6_ones",  out_ones,  4);
    check("t6_bytes", out_bytes, 1);
    step();

    // Reset in HOLD drops out_valid without a clock edge.
    out_ready = 1'b0;
    send_beat(8'h01, 1'b1, 0);
    @(negedge clk);
    check("t7_valid", out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check("t7_valid_async",   out_valid,   0);
    check("t7_valid_async_s", out_valid_s, 0);
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    step();

    // Randomized stream.
    repeat (3000) begin
      in_valid  = ($urandom_range(0, 99) < 70);
      in_data   = 8'($urandom);
      in_last   = ($urandom_range(0, 5) == 0);
      out_ready = ($urandom_range(0, 99) < 60);
      rst       = ($urandom_range(0, 999) == 0);
      step();
    end

    rst       = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (5) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
